// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// The optional expected-table comparison is enabled with the TT_CHECK_EN macro.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DONE
    } tt_state_e;

    localparam int SETTLE_W = 8;

    function automatic int tt_len(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times the settle window for each stimulus vector.
// The counter saturates at zero and asserts zero_o while it is there.
module tt_settle_timer
    import tt_sweep_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                dec_i,
    input  logic [SETTLE_W-1:0] load_val_i,
    output logic                zero_o
);

    logic [SETTLE_W-1:0] count_q;
    logic [SETTLE_W-1:0] count_d;

    // Load has priority, so a new window can start on the same edge the old one expires.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2**N_IN input vectors, holds each for SETTLE cycles and captures y_in into a table.
// Defining TT_CHECK_EN adds the expected/mismatch ports for a built-in table comparison.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [N_IN-1:0]         stim,
    input  logic                    y_in,
    output logic                    busy,
    output logic                    done,
    output logic [tt_len(N_IN)-1:0] truth
`ifdef TT_CHECK_EN
    ,
    input  logic [tt_len(N_IN)-1:0] expected,
    output logic                    mismatch
`endif
);

    localparam int                  LEN       = tt_len(N_IN);
    localparam logic [SETTLE_W-1:0] SETTLE_M1 = SETTLE_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]     STIM_LAST = {N_IN{1'b1}};

    tt_state_e       state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [LEN-1:0]  truth_q, truth_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tmrLoad;
    logic            tmrDec;
    logic            tmrZero;

    tt_settle_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmrLoad),
        .dec_i     (tmrDec),
        .load_val_i(SETTLE_M1),
        .zero_o    (tmrZero)
    );

    // y_in is only looked at when the settle window expires, so earlier glitches are ignored.
    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        truth_d = truth_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tmrLoad = 1'b0;
        tmrDec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stim_d  = '0;
                    truth_d = '0;
                    busy_d  = 1'b1;
                    tmrLoad = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!tmrZero) begin
                    tmrDec = 1'b1;
                end else begin
                    truth_d[stim_q] = y_in;
                    if (stim_q != STIM_LAST) begin
                        stim_d  = stim_q + 1'b1;
                        tmrLoad = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stim_q  <= '0;
            truth_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            truth_q <= truth_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign stim  = stim_q;
    assign truth = truth_q;
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef TT_CHECK_EN
    logic mismatch_q, mismatch_d;

    // Compare against truth_d so the final sample taken on the DONE entry edge is included.
    always_comb begin
        mismatch_d = mismatch_q;
        if ((state_q == IDLE) && start) begin
            mismatch_d = 1'b0;
        end else if ((state_q == HOLD) && tmrZero && (stim_q == STIM_LAST)) begin
            mismatch_d = (truth_d != expected);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper with three instances (SETTLE = 1, 2, 3).
// Checks of the mismatch port are compiled in when TT_CHECK_EN is defined.
module tb_truth_table_sweeper;

    typedef struct {
        logic [15:0] truth;
        int          doneCyc;
    } expEntry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start2, start3;
    logic [3:0]  stim1, stim2, stim3;
    logic        y1, y2, y3;
    logic        busy1, busy2, busy3;
    logic        done1, done2, done3;
    logic [15:0] truth1, truth2, truth3;
    logic        orMode;
    logic        ph = 1'b0;
`ifdef TT_CHECK_EN
    logic [15:0] expected1;
    logic        mismatch1, mismatch2, mismatch3;
`endif

    int        cyc    = 0;
    int        checks = 0;
    int        errors = 0;
    int        busyCnt[3];
    expEntry_t sb[3][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Glitch source for the SETTLE=2 instance: high only in the first cycle of each window.
    always @(posedge clk) ph <= busy2 ? ~ph : 1'b0;

    assign y1 = orMode ? (stim1[3] | stim1[0]) : (stim1[3] & stim1[2]);
    assign y2 = busy2 & ~ph;
    assign y3 = ^stim3;

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stim(stim1), .y_in(y1),
        .busy(busy1), .done(done1), .truth(truth1)
`ifdef TT_CHECK_EN
        , .expected(expected1), .mismatch(mismatch1)
`endif
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .stim(stim2), .y_in(y2),
        .busy(busy2), .done(done2), .truth(truth2)
`ifdef TT_CHECK_EN
        , .expected(16'h0000), .mismatch(mismatch2)
`endif
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .stim(stim3), .y_in(y3),
        .busy(busy3), .done(done3), .truth(truth3)
`ifdef TT_CHECK_EN
        , .expected(16'h0000), .mismatch(mismatch3)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic setStart(input int sel, input logic v);
        case (sel)
            0:       start1 = v;
            1:       start2 = v;
            default: start3 = v;
        endcase
    endtask

    function automatic logic doneOf(input int sel);
        case (sel)
            0:       return done1;
            1:       return done2;
            default: return done3;
        endcase
    endfunction

    // Caller is at a negedge; the start is accepted on the next rising edge.
    task automatic applyStimulus(input int sel, input logic [15:0] expTruth, input int lat,
                                 input bit doPush);
        expEntry_t e;
        setStart(sel, 1'b1);
        e.truth   = expTruth;
        e.doneCyc = cyc + 1 + lat;
        if (doPush) sb[sel].push_back(e);
        @(negedge clk);
        setStart(sel, 1'b0);
    endtask

    task automatic waitDone(input int sel, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = doneOf(sel);
        end
        checkOutput($sformatf("done%0d seen", sel + 1), 32'(seen), 32'd1);
    endtask

    task automatic waitStim1(input logic [3:0] v);
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (stim1 == v) hit = 1'b1;
            else @(negedge clk);
        end
        checkOutput($sformatf("stim1 reaches %0d", v), 32'(hit), 32'd1);
    endtask

    task automatic monitorOne(input int sel, input logic d, input logic b,
                              input logic [15:0] t, input int len);
        expEntry_t e;
        if (b) busyCnt[sel]++;
        if (d) begin
            if (sb[sel].size() == 0) begin
                checkOutput($sformatf("dut%0d unexpected done", sel + 1), 32'd1, 32'd0);
            end else begin
                e = sb[sel].pop_front();
                checkOutput($sformatf("dut%0d truth", sel + 1), 32'(t), 32'(e.truth));
                checkOutput($sformatf("dut%0d done cycle", sel + 1), 32'(cyc), 32'(e.doneCyc));
                checkOutput($sformatf("dut%0d busy cycles", sel + 1), 32'(busyCnt[sel]), 32'(len));
            end
        end
        if (!b) busyCnt[sel] = 0;
    endtask

    // Scoreboard monitor: compares each done pulse against the queued expectation.
    always @(negedge clk) begin
        monitorOne(0, done1, busy1, truth1, 16);
        monitorOne(1, done2, busy2, truth2, 32);
        monitorOne(2, done3, busy3, truth3, 48);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time %0t exceeded limit 100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;
        expEntry_t e;
        rst    = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        orMode = 1'b0;
        busyCnt = '{0, 0, 0};
`ifdef TT_CHECK_EN
        expected1 = 16'hF000;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset stim1", 32'(stim1), 32'd0);
        checkOutput("reset busy1", 32'(busy1), 32'd0);
        checkOutput("reset done1", 32'(done1), 32'd0);
        checkOutput("reset truth1", 32'(truth1), 32'd0);
`ifdef TT_CHECK_EN
        checkOutput("reset mismatch1", 32'(mismatch1), 32'd0);
`endif

        // AND function, start accepted on edge 5
        while (cyc < 4) @(negedge clk);
        applyStimulus(0, 16'hF000, 16, 1'b1);
        waitDone(0, 30);
`ifdef TT_CHECK_EN
        checkOutput("mismatch1 clean", 32'(mismatch1), 32'd0);
`endif
        @(negedge clk);
        checkOutput("done1 one cycle", 32'(done1), 32'd0);
        checkOutput("stim1 parked", 32'(stim1), 32'hF);
        repeat (3) @(negedge clk);
        checkOutput("truth1 held", 32'(truth1), 32'hF000);

        // Parity with SETTLE=3: each vector held three cycles
        applyStimulus(2, 16'h6996, 48, 1'b1);
        for (int t = 0; t < 48; t++) begin
            if (t > 0) @(negedge clk);
            checkOutput("stim3 hold", 32'(stim3), 32'(t / 3));
        end
        waitDone(2, 10);

        // Start pulse mid-sweep is ignored
        applyStimulus(0, 16'hF000, 16, 1'b1);
        waitStim1(4'd7);
        setStart(0, 1'b1);
        @(negedge clk);
        setStart(0, 1'b0);
        waitDone(0, 30);
        repeat (20) @(negedge clk);

        // Reset mid-sweep discards the partial table
        orMode = 1'b1;
        applyStimulus(0, 16'h0000, 16, 1'b0);
        waitStim1(4'd9);
        checkOutput("truth1 partial", 32'(truth1), 32'h01AA);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy1", 32'(busy1), 32'd0);
        checkOutput("abort stim1", 32'(stim1), 32'd0);
        checkOutput("abort truth1", 32'(truth1), 32'd0);
        checkOutput("abort done1", 32'(done1), 32'd0);
        repeat (20) @(negedge clk);
        orMode = 1'b0;
        applyStimulus(0, 16'hF000, 16, 1'b1);
        waitDone(0, 30);

        // Glitchy constant-zero function with SETTLE=2
        applyStimulus(1, 16'h0000, 32, 1'b1);
        waitDone(1, 45);

        // start held high: back-to-back sweeps with one idle cycle between
        @(negedge clk);
        setStart(0, 1'b1);
        e0 = cyc + 1;
        e.truth = 16'hF000;
        e.doneCyc = e0 + 16;
        sb[0].push_back(e);
        e.doneCyc = e0 + 34;
        sb[0].push_back(e);
        waitDone(0, 30);
        @(negedge clk);
        checkOutput("gap busy1 low", 32'(busy1), 32'd0);
        @(negedge clk);
        checkOutput("restart busy1 high", 32'(busy1), 32'd1);
        setStart(0, 1'b0);
        waitDone(0, 30);

`ifdef TT_CHECK_EN
        // Expected table differs from the captured one
        expected1 = 16'hF001;
        @(negedge clk);
        applyStimulus(0, 16'hF000, 16, 1'b1);
        waitDone(0, 30);
        checkOutput("mismatch1 set", 32'(mismatch1), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("mismatch1 sticky", 32'(mismatch1), 32'd1);
        applyStimulus(0, 16'hF000, 16, 1'b1);
        checkOutput("mismatch1 cleared on start", 32'(mismatch1), 32'd0);
        waitDone(0, 30);
        checkOutput("mismatch1 set again", 32'(mismatch1), 32'd1);
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
